// File: rtl/teng_pkg.sv
// Shared 10GBASE-R PCS definitions: sync headers, scrambler taps, block widths
// and the two-entry buffer state encoding used by scrambler and gearbox.
package teng_pkg;

  localparam logic [1:0] SYNC_DATA = 2'b01;
  localparam logic [1:0] SYNC_CTRL = 2'b10;

  localparam int unsigned SCR_TAP_A = 39;
  localparam int unsigned SCR_TAP_B = 58;

  localparam int unsigned BLK_W     = 66;
  localparam int unsigned PAYLOAD_W = 64;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } buf_state_e;

  function automatic logic hdr_invalid(input logic [1:0] hdr);
    return (hdr != SYNC_DATA) && (hdr != SYNC_CTRL);
  endfunction

endpackage

// File: rtl/skid_buf.sv
// Two-entry skid buffer with registered ready; output comes from the main
// register only, the skid register absorbs the one block in flight on a stall.
module skid_buf
  import teng_pkg::*;
#(
  parameter int unsigned W = 66
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic [W-1:0] in_data_i,
  input  logic         in_vld_i,
  output logic         in_rdy_o,
  output logic [W-1:0] out_data_o,
  output logic         out_vld_o,
  input  logic         out_rdy_i
);

  buf_state_e   state_q;
  logic [W-1:0] main_q;
  logic [W-1:0] skid_q;
  logic         vld_q;
  logic         rdy_q;
  logic         acc;
  logic         xfer;

  assign acc  = in_vld_i & rdy_q;
  assign xfer = vld_q & out_rdy_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      vld_q   <= 1'b0;
      rdy_q   <= 1'b1;
    end else begin
      case (state_q)
        EMPTY: begin
          if (acc) begin
            main_q  <= in_data_i;
            vld_q   <= 1'b1;
            state_q <= ONE;
          end
        end
        ONE: begin
          if (acc && !xfer) begin
            skid_q  <= in_data_i;
            state_q <= TWO;
            rdy_q   <= 1'b0;
          end else if (!acc && xfer) begin
            vld_q   <= 1'b0;
            state_q <= EMPTY;
          end else if (acc && xfer) begin
            main_q  <= in_data_i;
          end
        end
        TWO: begin
          // ready is low here, so only the drain of main can happen
          if (xfer) begin
            main_q  <= skid_q;
            state_q <= ONE;
            rdy_q   <= 1'b1;
          end
        end
        default: begin
          state_q <= EMPTY;
          vld_q   <= 1'b0;
          rdy_q   <= 1'b1;
        end
      endcase
    end
  end

  assign in_rdy_o   = rdy_q;
  assign out_data_o = main_q;
  assign out_vld_o  = vld_q;

endmodule

// File: rtl/scramble.sv
// 10GBASE-R transmit scrambler, G(x) = 1 + x^39 + x^58, applied to the 64-bit
// payload of each accepted block; sync header passes through untouched.
module scramble
  import teng_pkg::*;
#(
  parameter logic [57:0] SEED  = 58'h3,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [65:0]      data_i,
  input  logic             data_vld_i,
  output logic             data_rdy_o,
  output logic [65:0]      data_o,
  output logic             data_vld_o,
  input  logic             data_rdy_i,
  input  logic             bypass_i,
  input  logic             seed_load_i,
  input  logic [57:0]      seed_i,
  output logic             hdr_err_o,
  output logic [CNT_W-1:0] blk_cnt_o
);

  logic [SCR_TAP_B-1:0] scr_q;
  logic [SCR_TAP_B-1:0] scr_base;
  logic [SCR_TAP_B-1:0] scr_next;
  logic [PAYLOAD_W-1:0] pay_scr;
  logic [BLK_W-1:0]     blk_d;
  logic                 accept;
  logic                 xfer;
  logic                 hdr_err_q;
  logic [CNT_W-1:0]     cnt_q;

  assign accept = data_vld_i & data_rdy_o;
  assign xfer   = data_vld_o & data_rdy_i;

  // ext holds the bit stream oldest-first: [57:0] is history, [121:58] the new block
  always_comb begin : lfsr
    logic [PAYLOAD_W+SCR_TAP_B-1:0] ext;
    scr_base = seed_load_i ? seed_i : scr_q;
    ext      = '0;
    for (int unsigned j = 0; j < SCR_TAP_B; j++)
      ext[SCR_TAP_B-1-j] = scr_base[j];
    for (int unsigned k = 0; k < PAYLOAD_W; k++)
      ext[k+SCR_TAP_B] = data_i[k+2] ^ ext[k+SCR_TAP_B-SCR_TAP_A] ^ ext[k];
    pay_scr = ext[PAYLOAD_W+SCR_TAP_B-1:SCR_TAP_B];
    scr_next = '0;
    for (int unsigned j = 0; j < SCR_TAP_B; j++)
      scr_next[j] = ext[PAYLOAD_W+SCR_TAP_B-1-j];
  end

  assign blk_d = {bypass_i ? data_i[65:2] : pay_scr, data_i[1:0]};

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      scr_q     <= SEED;
      hdr_err_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      if (accept && !bypass_i)
        scr_q <= scr_next;
      else if (seed_load_i)
        scr_q <= seed_i;
      hdr_err_q <= accept & hdr_invalid(data_i[1:0]);
      if (xfer)
        cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  skid_buf #(
    .W (BLK_W)
  ) u_skid (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .in_data_i  (blk_d),
    .in_vld_i   (data_vld_i),
    .in_rdy_o   (data_rdy_o),
    .out_data_o (data_o),
    .out_vld_o  (data_vld_o),
    .out_rdy_i  (data_rdy_i)
  );

  assign hdr_err_o = hdr_err_q;
  assign blk_cnt_o = cnt_q;

endmodule

// File: tb/tb_scramble.sv
// Directed bench for scramble: hand-computed anchor vectors plus a bit-serial
// scrambler/descrambler model and an output queue for ordering and flow control.
module tb_scramble;

  localparam logic [57:0] SEED  = 58'h3;
  localparam int unsigned CNT_W = 4;

  logic             clk_i = 1'b0;
  logic             rst_n_i;
  logic [65:0]      data_i;
  logic             data_vld_i;
  logic             data_rdy_o;
  logic [65:0]      data_o;
  logic             data_vld_o;
  logic             data_rdy_i;
  logic             bypass_i;
  logic             seed_load_i;
  logic [57:0]      seed_i;
  logic             hdr_err_o;
  logic [CNT_W-1:0] blk_cnt_o;

  scramble #(
    .SEED  (SEED),
    .CNT_W (CNT_W)
  ) dut (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .data_i      (data_i),
    .data_vld_i  (data_vld_i),
    .data_rdy_o  (data_rdy_o),
    .data_o      (data_o),
    .data_vld_o  (data_vld_o),
    .data_rdy_i  (data_rdy_i),
    .bypass_i    (bypass_i),
    .seed_load_i (seed_load_i),
    .seed_i      (seed_i),
    .hdr_err_o   (hdr_err_o),
    .blk_cnt_o   (blk_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [65:0] exp;
    logic [65:0] plain;
    logic        byp;
  } ent_t;

  ent_t             q[$];
  logic [57:0]      tx_st;
  logic [57:0]      rx_st;
  logic [CNT_W-1:0] cnt_exp;
  logic             chk_rx;
  int               n_vec;
  int               n_miss;

  task automatic check(input string tag, input logic [65:0] got, input logic [65:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] scr64(input logic [63:0] d, input logic [57:0] si,
                                        output logic [57:0] so);
    logic [63:0] o;
    logic [57:0] st;
    logic        b;
    st = si;
    for (int k = 0; k < 64; k++) begin
      b    = d[k] ^ st[38] ^ st[57];
      o[k] = b;
      st   = {st[56:0], b};
    end
    so = st;
    return o;
  endfunction

  function automatic logic [63:0] dscr64(input logic [63:0] c, input logic [57:0] si,
                                         output logic [57:0] so);
    logic [63:0] o;
    logic [57:0] st;
    st = si;
    for (int k = 0; k < 64; k++) begin
      o[k] = c[k] ^ st[38] ^ st[57];
      st   = {st[56:0], c[k]};
    end
    so = st;
    return o;
  endfunction

  task automatic step(input logic v, input logic [65:0] d, input logic byp,
                      input logic sl, input logic [57:0] sd, input logic rdy);
    logic        acc, xfer, hdr_exp, pvld, prdy;
    logic [65:0] pdata;
    logic [63:0] pl;
    logic [57:0] nst;
    ent_t        e;
    data_vld_i  = v;
    data_i      = d;
    bypass_i    = byp;
    seed_load_i = sl;
    seed_i      = sd;
    data_rdy_i  = rdy;
    acc   = v && data_rdy_o;
    xfer  = data_vld_o && rdy;
    pvld  = data_vld_o;
    prdy  = rdy;
    pdata = data_o;
    if (xfer) begin
      if (q.size() == 0) begin
        check("spurious_out", data_o, 66'h0);
      end else begin
        e = q.pop_front();
        check("data_o", data_o, e.exp);
        if (!e.byp) begin
          pl = dscr64(data_o[65:2], rx_st, nst);
          rx_st = nst;
          if (chk_rx) check("descrambled", {pl, data_o[1:0]}, e.plain);
        end
      end
      if (cnt_exp == 4'hF) begin
        @(posedge clk_i);
        #1;
        check("cnt_wrap", 66'(blk_cnt_o), 66'h0);
        cnt_exp = cnt_exp + 4'h1;
      end else begin
        cnt_exp = cnt_exp + 4'h1;
        @(posedge clk_i);
        #1;
      end
    end else begin
      @(posedge clk_i);
      #1;
    end
    if (sl) tx_st = sd;
    if (acc) begin
      e.plain = d;
      e.byp   = byp;
      if (byp) begin
        e.exp = d;
      end else begin
        e.exp = {scr64(d[65:2], tx_st, nst), d[1:0]};
        tx_st = nst;
      end
      q.push_back(e);
    end
    hdr_exp = acc && (d[1:0] == 2'b00 || d[1:0] == 2'b11);
    check("hdr_err_o", 66'(hdr_err_o), 66'(hdr_exp));
    check("blk_cnt_o", 66'(blk_cnt_o), 66'(cnt_exp));
    check("data_vld_o", 66'(data_vld_o), 66'(q.size() != 0));
    check("data_rdy_o", 66'(data_rdy_o), 66'(q.size() < 2));
    if (pvld && !prdy) check("held_stable", data_o, pdata);
  endtask

  task automatic drain();
    for (int i = 0; i < 8 && q.size() != 0; i++)
      step(1'b0, 66'h0, 1'b0, 1'b0, 58'h0, 1'b1);
    check("drained", 66'(q.size()), 66'h0);
  endtask

  initial begin
    n_vec       = 0;
    n_miss      = 0;
    chk_rx      = 1'b0;
    tx_st       = SEED;
    rx_st       = SEED;
    cnt_exp     = '0;
    rst_n_i     = 1'b0;
    data_i      = '0;
    data_vld_i  = 1'b0;
    data_rdy_i  = 1'b1;
    bypass_i    = 1'b0;
    seed_load_i = 1'b0;
    seed_i      = '0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_n_i = 1'b1;

    check("rst_vld", 66'(data_vld_o), 66'h0);
    check("rst_data", data_o, 66'h0);
    check("rst_rdy", 66'(data_rdy_o), 66'h1);
    check("rst_hdr_err", 66'(hdr_err_o), 66'h0);
    check("rst_cnt", 66'(blk_cnt_o), 66'h0);

    // Seed 3, zero payload: bits 37,38,56,57 set
    step(1'b1, {64'h0, 2'b01}, 1'b0, 1'b0, 58'h0, 1'b1);
    check("first_blk", data_o, {64'h0300_0060_0000_0000, 2'b01});
    check("first_vld", 66'(data_vld_o), 66'h1);

    step(1'b1, {64'hDEAD_BEEF_0123_4567, 2'b10}, 1'b1, 1'b0, 58'h0, 1'b1);
    check("bypass_blk", data_o, {64'hDEAD_BEEF_0123_4567, 2'b10});

    // Second zero block from the state left by the first: bits 12,13,50,52
    step(1'b1, {64'h0, 2'b01}, 1'b0, 1'b0, 58'h0, 1'b1);
    check("after_bypass", data_o, {64'h0014_0000_0000_3000, 2'b01});
    drain();

    step(1'b1, {64'h1111_2222_3333_4444, 2'b01}, 1'b0, 1'b0, 58'h0, 1'b0);
    step(1'b1, {64'h5555_6666_7777_8888, 2'b10}, 1'b0, 1'b0, 58'h0, 1'b0);
    check("stall_rdy_low", 66'(data_rdy_o), 66'h0);
    step(1'b1, {64'h9999_AAAA_BBBB_CCCC, 2'b01}, 1'b0, 1'b0, 58'h0, 1'b0);
    check("stall_two_held", 66'(q.size()), 66'h2);
    step(1'b1, {64'h9999_AAAA_BBBB_CCCC, 2'b01}, 1'b0, 1'b0, 58'h0, 1'b1);
    step(1'b1, {64'h9999_AAAA_BBBB_CCCC, 2'b01}, 1'b0, 1'b0, 58'h0, 1'b1);
    drain();

    step(1'b1, {64'h0, 2'b01}, 1'b0, 1'b1, 58'h0, 1'b1);
    check("seed0_blk", data_o, {64'h0, 2'b01});
    step(1'b1, {64'h0, 2'b01}, 1'b0, 1'b0, 58'h0, 1'b1);
    check("seed0_next", data_o, {64'h0, 2'b01});
    drain();

    step(1'b1, {64'h0123_4567_89AB_CDEF, 2'b11}, 1'b0, 1'b0, 58'h0, 1'b1);
    check("hdr11_pulse", 66'(hdr_err_o), 66'h1);
    step(1'b0, 66'h0, 1'b0, 1'b0, 58'h0, 1'b1);
    check("hdr11_clear", 66'(hdr_err_o), 66'h0);
    drain();

    step(1'b1, {64'hAAAA_AAAA_AAAA_AAAA, 2'b01}, 1'b0, 1'b0, 58'h0, 1'b0);
    step(1'b1, {64'h5555_5555_5555_5555, 2'b10}, 1'b0, 1'b0, 58'h0, 1'b0);
    rst_n_i = 1'b0;
    #1;
    check("midrst_vld", 66'(data_vld_o), 66'h0);
    check("midrst_data", data_o, 66'h0);
    check("midrst_rdy", 66'(data_rdy_o), 66'h1);
    q.delete();
    tx_st   = SEED;
    rx_st   = SEED;
    cnt_exp = '0;
    @(posedge clk_i);
    #1;
    rst_n_i = 1'b1;
    step(1'b1, {64'h0, 2'b01}, 1'b0, 1'b0, 58'h0, 1'b1);
    check("midrst_reseed", data_o, {64'h0300_0060_0000_0000, 2'b01});

    chk_rx = 1'b1;
    for (int i = 0; i < 60; i++)
      step($urandom_range(0, 3) != 0, {$urandom(), $urandom(), $urandom_range(0, 1) ? 2'b01 : 2'b10},
           1'b0, 1'b0, 58'h0, $urandom_range(0, 3) != 0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
